// File: rtl/uart_cfg_if.sv
// Bus-side handshake of uart_cfg: TX push, RX pop, fill levels and error flags.
interface uart_cfg_if #(
   parameter int unsigned DBIT   = 8,
   parameter int unsigned FIFO_W = 2
);
   logic            wr_uart;
   logic [DBIT-1:0] w_data;
   logic            rd_uart;
   logic            clr_err;
   logic [DBIT-1:0] r_data;
   logic            r_perr;
   logic            r_ferr;
   logic            rx_empty;
   logic            tx_full;
   logic            tx_empty;
   logic [FIFO_W:0] rx_level;
   logic [FIFO_W:0] tx_level;
   logic            overrun;

   modport master (
      output wr_uart, w_data, rd_uart, clr_err,
      input  r_data, r_perr, r_ferr, rx_empty, tx_full, tx_empty, rx_level, tx_level, overrun
   );
   modport slave (
      input  wr_uart, w_data, rd_uart, clr_err,
      output r_data, r_perr, r_ferr, rx_empty, tx_full, tx_empty, rx_level, tx_level, overrun
   );
endinterface

// File: rtl/uart_cfg.sv
// Full-duplex UART: programmable baud divisor, optional parity, per-word RX error flags,
// sticky overrun, and first-word-fall-through RX/TX FIFOs with fill levels.
module uart_cfg #(
   parameter int unsigned DBIT     = 8,
   parameter int unsigned SB_TICK  = 16,
   parameter int unsigned DVSR_BIT = 11,
   parameter int unsigned FIFO_W   = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DVSR_BIT-1:0] dvsr,
   input  logic                par_en,
   input  logic                par_odd,
   input  logic                rx,
   output logic                tx,
   uart_cfg_if.slave           bus
);
   localparam int unsigned     DEPTH    = 2 ** FIFO_W;
   localparam logic [FIFO_W:0] FULL_LVL = (FIFO_W + 1)'(DEPTH);
   localparam logic [5:0]      SB_LAST  = 6'(SB_TICK - 1);
   localparam logic [2:0]      D_LAST   = 3'(DBIT - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   // Baud tick; the >= also recovers when dvsr is lowered below the running count.
   logic [DVSR_BIT-1:0] baud_q;
   logic                tick;
   assign tick = (baud_q >= dvsr);
   always_ff @(posedge clk) begin
      if (reset || tick) baud_q <= '0;
      else               baud_q <= baud_q + DVSR_BIT'(1);
   end

   logic rx_meta_q, rx_sync_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // ---------------- RX engine ----------------
   state_e          rx_state_q, rx_state_d;
   logic [5:0]      rx_s_q, rx_s_d;
   logic [2:0]      rx_n_q, rx_n_d;
   logic [DBIT-1:0] rx_b_q, rx_b_d;
   logic            rx_pbit_q, rx_pbit_d, rx_pen_q, rx_pen_d, rx_podd_q, rx_podd_d;
   logic            rx_push, rx_ferr, rx_perr;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q <= StIdle;
         rx_s_q     <= '0;
         rx_n_q     <= '0;
         rx_b_q     <= '0;
         rx_pbit_q  <= 1'b0;
         rx_pen_q   <= 1'b0;
         rx_podd_q  <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_s_q     <= rx_s_d;
         rx_n_q     <= rx_n_d;
         rx_b_q     <= rx_b_d;
         rx_pbit_q  <= rx_pbit_d;
         rx_pen_q   <= rx_pen_d;
         rx_podd_q  <= rx_podd_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_s_d     = rx_s_q;
      rx_n_d     = rx_n_q;
      rx_b_d     = rx_b_q;
      rx_pbit_d  = rx_pbit_q;
      rx_pen_d   = rx_pen_q;
      rx_podd_d  = rx_podd_q;
      rx_push    = 1'b0;
      rx_ferr    = 1'b0;
      unique case (rx_state_q)
         StIdle: if (!rx_sync_q) begin
            rx_state_d = StStart;
            rx_s_d     = '0;
         end
         StStart: if (tick) begin
            if (rx_s_q == 6'd7) begin
               // Mid start bit: still low confirms a frame, high means a glitch.
               rx_state_d = rx_sync_q ? StIdle : StData;
               rx_s_d     = '0;
               rx_n_d     = '0;
               rx_pen_d   = par_en;
               rx_podd_d  = par_odd;
            end else rx_s_d = rx_s_q + 6'd1;
         end
         StData: if (tick) begin
            if (rx_s_q == 6'd15) begin
               rx_s_d = '0;
               rx_b_d = {rx_sync_q, rx_b_q[DBIT-1:1]};
               if (rx_n_q == D_LAST) rx_state_d = rx_pen_q ? StParity : StStop;
               else                  rx_n_d     = rx_n_q + 3'd1;
            end else rx_s_d = rx_s_q + 6'd1;
         end
         StParity: if (tick) begin
            if (rx_s_q == 6'd15) begin
               rx_s_d     = '0;
               rx_pbit_d  = rx_sync_q;
               rx_state_d = StStop;
            end else rx_s_d = rx_s_q + 6'd1;
         end
         StStop: if (tick) begin
            if (rx_s_q == SB_LAST) begin
               rx_push    = 1'b1;
               rx_ferr    = ~rx_sync_q;
               rx_state_d = StIdle;
            end else rx_s_d = rx_s_q + 6'd1;
         end
         default: rx_state_d = StIdle;
      endcase
   end

   assign rx_perr = rx_pen_q & (rx_pbit_q != ((^rx_b_q) ^ rx_podd_q));

   // ---------------- RX FIFO ----------------
   logic [DBIT+1:0]   rx_mem_q [DEPTH];
   logic [FIFO_W-1:0] rx_wp_q, rx_rp_q;
   logic [FIFO_W:0]   rx_cnt_q;
   logic              rx_full, rx_wr, rx_rd;
   logic              overrun_q;

   assign rx_full = (rx_cnt_q == FULL_LVL);
   assign rx_wr   = rx_push & ~rx_full;
   assign rx_rd   = bus.rd_uart & ~bus.rx_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) rx_mem_q[i] <= '0;
         rx_wp_q   <= '0;
         rx_rp_q   <= '0;
         rx_cnt_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (rx_wr) begin
            rx_mem_q[rx_wp_q] <= {rx_perr, rx_ferr, rx_b_q};
            rx_wp_q           <= rx_wp_q + FIFO_W'(1);
         end
         if (rx_rd) rx_rp_q <= rx_rp_q + FIFO_W'(1);
         case ({rx_wr, rx_rd})
            2'b10:   rx_cnt_q <= rx_cnt_q + (FIFO_W + 1)'(1);
            2'b01:   rx_cnt_q <= rx_cnt_q - (FIFO_W + 1)'(1);
            default: ;
         endcase
         overrun_q <= (overrun_q & ~bus.clr_err) | (rx_push & rx_full);
      end
   end

   assign {bus.r_perr, bus.r_ferr, bus.r_data} = rx_mem_q[rx_rp_q];
   assign bus.rx_empty = (rx_cnt_q == '0);
   assign bus.rx_level = rx_cnt_q;
   assign bus.overrun  = overrun_q;

   // ---------------- TX FIFO ----------------
   logic [DBIT-1:0]   tx_mem_q [DEPTH];
   logic [FIFO_W-1:0] tx_wp_q, tx_rp_q;
   logic [FIFO_W:0]   tx_cnt_q;
   logic              tx_wr, tx_load;

   assign tx_wr = bus.wr_uart & ~bus.tx_full;

   always_ff @(posedge clk) begin
      if (tx_wr) tx_mem_q[tx_wp_q] <= bus.w_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
      end else begin
         if (tx_wr)   tx_wp_q <= tx_wp_q + FIFO_W'(1);
         if (tx_load) tx_rp_q <= tx_rp_q + FIFO_W'(1);
         case ({tx_wr, tx_load})
            2'b10:   tx_cnt_q <= tx_cnt_q + (FIFO_W + 1)'(1);
            2'b01:   tx_cnt_q <= tx_cnt_q - (FIFO_W + 1)'(1);
            default: ;
         endcase
      end
   end

   assign bus.tx_full  = (tx_cnt_q == FULL_LVL);
   assign bus.tx_empty = (tx_cnt_q == '0);
   assign bus.tx_level = tx_cnt_q;

   // ---------------- TX engine ----------------
   state_e          tx_state_q, tx_state_d;
   logic [5:0]      tx_s_q, tx_s_d;
   logic [2:0]      tx_n_q, tx_n_d;
   logic [DBIT-1:0] tx_sh_q, tx_sh_d;
   logic            tx_pbit_q, tx_pbit_d, tx_pen_q, tx_pen_d, tx_q, tx_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q <= StIdle;
         tx_s_q     <= '0;
         tx_n_q     <= '0;
         tx_sh_q    <= '0;
         tx_pbit_q  <= 1'b0;
         tx_pen_q   <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_s_q     <= tx_s_d;
         tx_n_q     <= tx_n_d;
         tx_sh_q    <= tx_sh_d;
         tx_pbit_q  <= tx_pbit_d;
         tx_pen_q   <= tx_pen_d;
         tx_q       <= tx_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_s_d     = tx_s_q;
      tx_n_d     = tx_n_q;
      tx_sh_d    = tx_sh_q;
      tx_pbit_d  = tx_pbit_q;
      tx_pen_d   = tx_pen_q;
      tx_load    = 1'b0;
      unique case (tx_state_q)
         StIdle: tx_load = ~bus.tx_empty;
         StStart: if (tick) begin
            if (tx_s_q == 6'd15) begin
               tx_state_d = StData;
               tx_s_d     = '0;
               tx_n_d     = '0;
            end else tx_s_d = tx_s_q + 6'd1;
         end
         StData: if (tick) begin
            if (tx_s_q == 6'd15) begin
               tx_s_d  = '0;
               tx_sh_d = tx_sh_q >> 1;
               if (tx_n_q == D_LAST) tx_state_d = tx_pen_q ? StParity : StStop;
               else                  tx_n_d     = tx_n_q + 3'd1;
            end else tx_s_d = tx_s_q + 6'd1;
         end
         StParity: if (tick) begin
            if (tx_s_q == 6'd15) begin
               tx_s_d     = '0;
               tx_state_d = StStop;
            end else tx_s_d = tx_s_q + 6'd1;
         end
         StStop: if (tick) begin
            // A queued word starts straight from the stop bit: no idle gap.
            if (tx_s_q == SB_LAST) begin
               tx_state_d = StIdle;
               tx_load    = ~bus.tx_empty;
            end else tx_s_d = tx_s_q + 6'd1;
         end
         default: tx_state_d = StIdle;
      endcase
      if (tx_load) begin
         tx_state_d = StStart;
         tx_s_d     = '0;
         tx_sh_d    = tx_mem_q[tx_rp_q];
         tx_pbit_d  = (^tx_mem_q[tx_rp_q]) ^ par_odd;
         tx_pen_d   = par_en;
      end
      case (tx_state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = tx_sh_d[0];
         StParity: tx_d = tx_pbit_d;
         default:  tx_d = 1'b1;
      endcase
   end

   assign tx = tx_q;
endmodule
